// File: rtl/cont_pkg.sv
// Shared opcode, function-code and control-encoding definitions for the ID-stage decoder.
package cont_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b1111;
  localparam logic [3:0] OP_LBU   = 4'b1000;
  localparam logic [3:0] OP_SB    = 4'b1001;
  localparam logic [3:0] OP_LW    = 4'b1010;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_ANDI  = 4'b1100;
  localparam logic [3:0] OP_ORI   = 4'b1101;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0001;
  localparam logic [3:0] OP_HALT  = 4'b0000;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BLT  = 2'b01;
  localparam logic [1:0] BR_BGT  = 2'b10;
  localparam logic [1:0] BR_BEQ  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  // Control word carried down the ID/EX register; all-zero is the NOP word.
  typedef struct packed {
    logic       aluSrcA;
    logic       aluSrcB;
    logic [2:0] aluOP;
    logic       byteEN;
    logic       memW;
    logic       memR;
    logic       regW;
    logic       R15w;
    logic [1:0] WBsrc;
    logic       brnch;
    logic [1:0] brnchOP;
    logic       jmp;
    logic       IF_IDclr;
  } ctrlWord_t;

  localparam ctrlWord_t CTRL_NOP = '0;

endpackage

// File: rtl/cont_unit.sv
// ID-stage main decoder: opcode + R-type function code -> pipeline control word.
// Purely combinational; reset only masks the decoded word to NOP.
module cont_unit
  import cont_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] funcIn,
  input  logic [3:0] FuncCode,
  output logic       aluSrcA,
  output logic       aluSrcB,
  output logic [2:0] aluOP,
  output logic       byteEN,
  output logic       memW,
  output logic       memR,
  output logic       regW,
  output logic       R15w,
  output logic [1:0] WBsrc,
  output logic       brnch,
  output logic [1:0] brnchOP,
  output logic       jmp,
  output logic       IF_IDclr
);

  ctrlWord_t decWord;
  ctrlWord_t outWord;

  // Nothing here is clocked; clk exists only so the block matches its neighbours.
  logic unusedClk;
  assign unusedClk = clk;

  // Decode opcode (and function code for R-type) into a default-NOP control word.
  always_comb begin
    decWord = CTRL_NOP;
    case (funcIn)
      OP_RTYPE: begin
        case (FuncCode)
          FN_ADD: begin
            decWord.regW  = 1'b1;
            decWord.aluOP = ALU_ADD;
          end
          FN_SUB: begin
            decWord.regW  = 1'b1;
            decWord.aluOP = ALU_SUB;
          end
          FN_MUL: begin
            decWord.regW  = 1'b1;
            decWord.R15w  = 1'b1;
            decWord.aluOP = ALU_MUL;
          end
          FN_DIV: begin
            decWord.regW  = 1'b1;
            decWord.R15w  = 1'b1;
            decWord.aluOP = ALU_DIV;
          end
          default: decWord = CTRL_NOP;
        endcase
      end
      OP_LBU: begin
        decWord.aluSrcA = 1'b1;
        decWord.aluSrcB = 1'b1;
        decWord.byteEN  = 1'b1;
        decWord.memR    = 1'b1;
        decWord.regW    = 1'b1;
        decWord.WBsrc   = WB_MEM;
        decWord.aluOP   = ALU_ADD;
      end
      OP_SB: begin
        decWord.aluSrcA = 1'b1;
        decWord.aluSrcB = 1'b1;
        decWord.byteEN  = 1'b1;
        decWord.memW    = 1'b1;
        decWord.aluOP   = ALU_ADD;
      end
      OP_LW: begin
        decWord.aluSrcA = 1'b1;
        decWord.aluSrcB = 1'b1;
        decWord.memR    = 1'b1;
        decWord.regW    = 1'b1;
        decWord.WBsrc   = WB_MEM;
        decWord.aluOP   = ALU_ADD;
      end
      OP_SW: begin
        decWord.aluSrcA = 1'b1;
        decWord.aluSrcB = 1'b1;
        decWord.memW    = 1'b1;
        decWord.aluOP   = ALU_ADD;
      end
      OP_ANDI: begin
        decWord.aluSrcB = 1'b1;
        decWord.regW    = 1'b1;
        decWord.aluOP   = ALU_AND;
      end
      OP_ORI: begin
        decWord.aluSrcB = 1'b1;
        decWord.regW    = 1'b1;
        decWord.aluOP   = ALU_OR;
      end
      OP_BLT: begin
        decWord.brnch   = 1'b1;
        decWord.brnchOP = BR_BLT;
      end
      OP_BGT: begin
        decWord.brnch   = 1'b1;
        decWord.brnchOP = BR_BGT;
      end
      OP_BEQ: begin
        decWord.brnch   = 1'b1;
        decWord.brnchOP = BR_BEQ;
      end
      // Only JMP flushes IF/ID here; branch flushes are resolved later in the pipe.
      OP_JMP: begin
        decWord.jmp      = 1'b1;
        decWord.IF_IDclr = 1'b1;
      end
      default: decWord = CTRL_NOP;
    endcase
  end

  // Reset masks the word asynchronously; release is immediate, no clock edge needed.
  always_comb begin
    outWord = decWord;
    if (rst) outWord = CTRL_NOP;
  end

  assign aluSrcA  = outWord.aluSrcA;
  assign aluSrcB  = outWord.aluSrcB;
  assign aluOP    = outWord.aluOP;
  assign byteEN   = outWord.byteEN;
  assign memW     = outWord.memW;
  assign memR     = outWord.memR;
  assign regW     = outWord.regW;
  assign R15w     = outWord.R15w;
  assign WBsrc    = outWord.WBsrc;
  assign brnch    = outWord.brnch;
  assign brnchOP  = outWord.brnchOP;
  assign jmp      = outWord.jmp;
  assign IF_IDclr = outWord.IF_IDclr;

endmodule

// File: tb/tb_cont_unit.sv
// Directed bench for cont_unit. Observed word packs outputs as
// {aluSrcA,aluSrcB,aluOP[2:0],byteEN,memW,memR,regW,R15w,WBsrc[1:0],brnch,brnchOP[1:0],jmp,IF_IDclr}.
module tb_cont_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] funcIn;
  logic [3:0] FuncCode;
  logic       aluSrcA, aluSrcB, byteEN, memW, memR, regW, R15w, brnch, jmp, IF_IDclr;
  logic [2:0] aluOP;
  logic [1:0] WBsrc, brnchOP;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cont_unit dut (
    .clk(clk), .rst(rst), .funcIn(funcIn), .FuncCode(FuncCode),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOP(aluOP), .byteEN(byteEN),
    .memW(memW), .memR(memR), .regW(regW), .R15w(R15w), .WBsrc(WBsrc),
    .brnch(brnch), .brnchOP(brnchOP), .jmp(jmp), .IF_IDclr(IF_IDclr)
  );

  logic [16:0] obs;
  assign obs = {aluSrcA, aluSrcB, aluOP, byteEN, memW, memR, regW, R15w,
                WBsrc, brnch, brnchOP, jmp, IF_IDclr};

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive away from posedge and settle 1 time unit before sampling.
  task automatic apply(input logic r, input logic [3:0] op, input logic [3:0] fn);
    rst = r; funcIn = op; FuncCode = fn;
    #1;
  endtask

  initial begin
    rst = 1'b1; funcIn = 4'b1111; FuncCode = 4'b0000;
    @(negedge clk);
    apply(1'b1, 4'b1111, 4'b0000); chk("reset_add",   17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    // Release mid-cycle: output must appear without a clock edge.
    #1;
    apply(1'b0, 4'b1111, 4'b0000); chk("release_add", 17'b0_0_000_0_0_0_1_0_00_0_00_0_0);

    apply(1'b0, 4'b1111, 4'b0001); chk("r_sub",       17'b0_0_001_0_0_0_1_0_00_0_00_0_0);
    apply(1'b0, 4'b1111, 4'b0100); chk("r_mul",       17'b0_0_100_0_0_0_1_1_00_0_00_0_0);
    apply(1'b0, 4'b1111, 4'b0101); chk("r_div",       17'b0_0_101_0_0_0_1_1_00_0_00_0_0);
    apply(1'b0, 4'b1111, 4'b0010); chk("r_undef",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b1111, 4'b1111); chk("r_undef_f",   17'b0_0_000_0_0_0_0_0_00_0_00_0_0);

    apply(1'b0, 4'b1000, 4'b0000); chk("lbu",         17'b1_1_000_1_0_1_1_0_01_0_00_0_0);
    apply(1'b0, 4'b1001, 4'b0000); chk("sb",          17'b1_1_000_1_1_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b1010, 4'b0000); chk("lw",          17'b1_1_000_0_0_1_1_0_01_0_00_0_0);
    apply(1'b0, 4'b1011, 4'b0000); chk("sw",          17'b1_1_000_0_1_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b1010, 4'b0100); chk("lw_fn_ign",   17'b1_1_000_0_0_1_1_0_01_0_00_0_0);

    apply(1'b0, 4'b1100, 4'b0000); chk("andi",        17'b0_1_010_0_0_0_1_0_00_0_00_0_0);
    apply(1'b0, 4'b1101, 4'b0101); chk("ori",         17'b0_1_011_0_0_0_1_0_00_0_00_0_0);

    apply(1'b0, 4'b0101, 4'b0000); chk("blt",         17'b0_0_000_0_0_0_0_0_00_1_01_0_0);
    apply(1'b0, 4'b0100, 4'b0000); chk("bgt",         17'b0_0_000_0_0_0_0_0_00_1_10_0_0);
    apply(1'b0, 4'b0110, 4'b0001); chk("beq",         17'b0_0_000_0_0_0_0_0_00_1_11_0_0);

    apply(1'b0, 4'b0001, 4'b0000); chk("jmp",         17'b0_0_000_0_0_0_0_0_00_0_00_1_1);

    apply(1'b0, 4'b0000, 4'b0000); chk("halt",        17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b0010, 4'b0000); chk("op_0010",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b0011, 4'b0100); chk("op_0011",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b0111, 4'b0000); chk("op_0111",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b1110, 4'b0000); chk("op_1110",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);

    // Asynchronous reset assertion on a busy word, away from any edge.
    apply(1'b0, 4'b1000, 4'b0000); chk("lbu_pre",     17'b1_1_000_1_0_1_1_0_01_0_00_0_0);
    apply(1'b1, 4'b1000, 4'b0000); chk("rst_lbu",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b1, 4'b0001, 4'b0000); chk("rst_jmp",     17'b0_0_000_0_0_0_0_0_00_0_00_0_0);
    apply(1'b0, 4'b0001, 4'b0000); chk("jmp_post",    17'b0_0_000_0_0_0_0_0_00_0_00_1_1);

    // Outputs must not change across clock edges with stable inputs.
    apply(1'b0, 4'b1111, 4'b0101);
    @(posedge clk); #1;            chk("div_hold",    17'b0_0_101_0_0_0_1_1_00_0_00_0_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
